// File: rtl/fmul_stream_ctrl.sv
`default_nettype none
//============================================================================
// Module   : fmul_stream_ctrl
// Brief    : Valid/ready stream front-end for a free-running 8-cycle float
//            multiplier core. Issues operand pairs on frame boundaries only
//            when a FIFO slot is guaranteed, and buffers each product with
//            its IEEE class flags {nan, inf, zero}.
// Revision : 1.0 - initial release
//============================================================================
module fmul_stream_ctrl #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   input  logic [31:0]      mul_z,
   input  logic             mul_valid,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_z,
   output logic [2:0]       out_flags,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH) + 1;
   localparam logic [c_CNT_W:0]   c_DEPTH_X = (c_CNT_W+1)'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_DEPTH_C = c_CNT_W'(DEPTH);

   logic                r_first;
   logic                r_pending;
   logic [31:0]         r_mul_a;
   logic [31:0]         r_mul_b;
   logic [c_CNT_W-1:0]  r_count;
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]    r_op_count;
   logic [31:0]         r_mem_z     [DEPTH];
   logic [2:0]          r_mem_flags [DEPTH];

   logic                w_boundary;
   logic                w_push;
   logic                w_pop;
   logic                w_accept;
   logic                w_not_empty;
   logic [c_CNT_W:0]    w_credit;
   logic [2:0]          w_z_flags;

   // A frame boundary is the core's valid pulse, or the very first cycle
   // after reset when core frame 0 begins.
   assign w_boundary  = mul_valid | r_first;
   assign w_push      = rst_n & w_boundary & r_pending;
   assign w_not_empty = (r_count != '0);
   assign out_valid   = rst_n & w_not_empty;
   assign w_pop       = out_valid & out_ready;

   // Credit check counts the result landing this cycle but not the same-cycle
   // pop, so in_ready has no combinational dependence on out_ready.
   assign w_credit = {1'b0, r_count} + {{c_CNT_W{1'b0}}, w_push};
   assign in_ready = rst_n & w_boundary & (w_credit < c_DEPTH_X);
   assign w_accept = in_valid & in_ready;

   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign op_count  = r_op_count;
   assign busy      = rst_n & (r_pending | w_not_empty);
   assign out_z     = out_valid ? r_mem_z[r_rd_ptr]     : 32'd0;
   assign out_flags = out_valid ? r_mem_flags[r_rd_ptr] : 3'd0;

   // Classify the core result; denormals are not reported as zero.
   always_comb begin
      w_z_flags = 3'b000;
      if (mul_z[30:23] == 8'hFF) begin
         w_z_flags[2] = (mul_z[22:0] != 23'd0);
         w_z_flags[1] = (mul_z[22:0] == 23'd0);
      end
      w_z_flags[0] = (mul_z[30:0] == 31'd0);
   end

   // Issue control: operands and the pending marker only change on boundaries.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_first   <= 1'b1;
         r_pending <= 1'b0;
         r_mul_a   <= 32'd0;
         r_mul_b   <= 32'd0;
      end else begin
         r_first <= 1'b0;
         if (w_boundary) begin
            r_pending <= w_accept;
            if (w_accept) begin
               r_mul_a <= in_a;
               r_mul_b <= in_b;
            end
         end
      end
   end

   // FIFO occupancy, pointers and completed-operation counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_op_count <= '0;
      end else begin
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
            r_op_count <= r_op_count + CNT_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
      end
   end

   // FIFO storage; the credit rule means a push never finds the FIFO full.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(w_push && (r_count == c_DEPTH_C)));
      end
      if (w_push) begin
         r_mem_z[r_wr_ptr]     <= mul_z;
         r_mem_flags[r_wr_ptr] <= w_z_flags;
      end
   end

endmodule
`default_nettype wire
